// File: rtl/ifq_pkg.sv
// Shared constants, width helper and pending-read entry type for the instruction fetch queue.
package ifq_pkg;

    localparam int IFQ_DATA_W      = 16;
    localparam int IFQ_ADDR_W      = 12;
    localparam int IFQ_DEPTH       = 4;
    localparam int IFQ_MEM_LAT     = 1;
    localparam int IFQ_RESET_PC    = 0;
    localparam int IFQ_PEND_ADDR_W = 32;

    function automatic int ifq_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Address field is sized for the widest supported ADDR_W; users take the low bits.
    typedef struct packed {
        logic                       valid;
        logic [IFQ_PEND_ADDR_W-1:0] addr;
    } ifq_pend_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous {pc, data} FIFO with a registered head; clear beats push and pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DATA_W = IFQ_DATA_W,
    parameter int ADDR_W = IFQ_ADDR_W,
    parameter int DEPTH  = IFQ_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            push,
    input  logic [DATA_W-1:0]               push_data,
    input  logic [ADDR_W-1:0]               push_pc,
    input  logic                            pop,
    output logic [ifq_cnt_w(DEPTH+1)-1:0]   count,
    output logic                            head_valid,
    output logic [DATA_W-1:0]               head_data,
    output logic [ADDR_W-1:0]               head_pc
);

    localparam int PW = ifq_cnt_w(DEPTH);
    localparam int CW = ifq_cnt_w(DEPTH + 1);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_next;
    logic [CW-1:0]     count_next;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_pop     = pop && (count != '0);
        do_push    = push && ((count != CW'(DEPTH)) || do_pop);
        rd_next    = rd_ptr + PW'(do_pop);
        count_next = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            data_mem[wr_ptr] <= push_data;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

    // The word landing in an otherwise empty queue bypasses storage into the head register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
            head_pc    <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(do_push);
            rd_ptr     <= rd_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (do_push && (wr_ptr == rd_next)) begin
                head_data <= push_data;
                head_pc   <= push_pc;
            end else if (count_next != '0) begin
                head_data <= data_mem[rd_next];
                head_pc   <= pc_mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: credit-limited sequential reads, latency pipe, decode queue, redirect.
// Optional IFQ_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DATA_W   = IFQ_DATA_W,
    parameter int ADDR_W   = IFQ_ADDR_W,
    parameter int DEPTH    = IFQ_DEPTH,
    parameter int MEM_LAT  = IFQ_MEM_LAT,
    parameter int RESET_PC = IFQ_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_en,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int CW = ifq_cnt_w(DEPTH + 1);

    ifq_pend_t         pend [MEM_LAT];
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     count;
    logic [31:0]       occ;
    logic              pop;
    logic              issue;
    logic              capture;
    logic              pend_addr_unused;

    // Outstanding words = queued + in the latency pipe + being requested now.
    always_comb begin
        occ = 32'(count) + 32'(mem_en);
        for (int i = 0; i < MEM_LAT; i++) begin
            occ = occ + 32'(pend[i].valid);
        end
        pop     = inst_valid && inst_ready;
        issue   = (occ - 32'(pop)) < 32'(DEPTH);
        capture = pend[MEM_LAT-1].valid;
    end

    assign pend_addr_unused = |pend[MEM_LAT-1].addr;
    assign mem_read         = mem_en;

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pend[i] <= '0;
            end
        end else begin
            pend[0] <= '{valid: mem_en, addr: IFQ_PEND_ADDR_W'(mem_addr)};
            for (int i = 1; i < MEM_LAT; i++) begin
                pend[i] <= pend[i-1];
            end
        end
    end

    // mem_addr advances only once its address has actually been requested, so
    // fetch_pc always equals mem_addr + 1 and a stall never skips an address.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en   <= 1'b0;
            mem_addr <= ADDR_W'(RESET_PC);
            fetch_pc <= ADDR_W'(RESET_PC) + ADDR_W'(1);
        end else if (redirect) begin
            mem_en   <= 1'b1;
            mem_addr <= redirect_pc;
            fetch_pc <= redirect_pc + ADDR_W'(1);
        end else begin
            mem_en <= issue;
            if (mem_en) begin
                mem_addr <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

    ifq_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect),
        .push       (capture),
        .push_data  (mem_din),
        .push_pc    (pend[MEM_LAT-1].addr[ADDR_W-1:0]),
        .pop        (pop),
        .count      (count),
        .head_valid (inst_valid),
        .head_data  (inst),
        .head_pc    (inst_pc)
    );

`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!inst_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a memory model returns addr+16'h1000, a scoreboard holds
// the expected in-order pc stream and a negedge monitor checks every accepted instruction.
module tb_inst_fetch_queue;
    import ifq_pkg::*;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_en;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    int                compared   = 0;
    int                mismatched = 0;
    int                pops       = 0;
    logic [ADDR_W-1:0] exp_q [$];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .MEM_LAT  (MEM_LAT),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_en      (mem_en),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready)
`ifdef IFQ_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    // Synchronous memory: data for a request in cycle T is on mem_din in cycle T+MEM_LAT.
    always @(posedge clk) begin
        rd_pipe[0] <= mem_en ? (DATA_W'(mem_addr) + 16'h1000) : 16'hDEAD;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_din = rd_pipe[MEM_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_from(input logic [ADDR_W-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(start + ADDR_W'(i));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted instruction must be the next expected pc with matching data.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] exp_pc;
        if (!reset && !redirect && inst_valid && inst_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_unexpected: got inst_pc %0h, expected no instruction", inst_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                check("inst_pc", 32'(inst_pc), 32'(exp_pc));
                check("inst", 32'(inst), 32'(DATA_W'(exp_pc) + 16'h1000));
            end
        end
    end

    initial begin
        int issued;
        int p0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        step(3);

        // Streaming from reset with decode always ready.
        reset      = 1'b0;
        inst_ready = 1'b1;
        expect_from(12'h000);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", 32'(inst), 32'd0);
        check("rst_inst_pc", 32'(inst_pc), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            step(1);
            check("stream_mem_en", 32'(mem_en), 32'd1);
            check("stream_mem_read", 32'(mem_read), 32'd1);
            check("stream_mem_addr", 32'(mem_addr), 32'(c - 1));
            if (c == 2) check("latency_c2_valid", 32'(inst_valid), 32'd0);
            if (c == 3) check("latency_c3_valid", 32'(inst_valid), 32'd1);
        end

        // Back-pressure: decode stalled for 20 cycles from a fresh reset.
        reset      = 1'b1;
        inst_ready = 1'b0;
        step(1);
        reset = 1'b0;
        expect_from(12'h000);
        issued = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (mem_en) issued++;
        end
        check("stall_issued", 32'(issued), 32'(DEPTH));
        check("stall_mem_en", 32'(mem_en), 32'd0);
        check("stall_inst_valid", 32'(inst_valid), 32'd1);
        check("stall_inst_pc", 32'(inst_pc), 32'd0);
        p0         = pops;
        inst_ready = 1'b1;
        step(12);
        check("resume_pops", 32'(pops - p0), 32'd12);

        // Redirect with two reads in flight.
        redirect    = 1'b1;
        redirect_pc = 12'h0A0;
        expect_from(12'h0A0);
        step(1);
        redirect = 1'b0;
        check("redir_mem_en", 32'(mem_en), 32'd1);
        check("redir_mem_addr", 32'(mem_addr), 32'h0A0);
        check("redir_r1_valid", 32'(inst_valid), 32'd0);
        step(1);
        check("redir_r2_valid", 32'(inst_valid), 32'd0);
        step(1);
        check("redir_r3_valid", 32'(inst_valid), 32'd1);
        check("redir_r3_pc", 32'(inst_pc), 32'h0A0);
        step(4);

        // Redirect near the top of the address space: pc must wrap to 000.
        redirect    = 1'b1;
        redirect_pc = 12'hFFE;
        expect_from(12'hFFE);
        p0 = pops;
        step(1);
        redirect = 1'b0;
        check("wrap_mem_addr", 32'(mem_addr), 32'hFFE);
        step(9);
        check("wrap_pops", 32'(pops - p0), 32'd7);
`ifdef IFQ_PERF_CNT_EN
        check("flush_cnt", flush_cnt, 32'd2);
`endif

        // Reset while the queue is filling and a read is still in flight.
        inst_ready = 1'b0;
        step(2);
        reset = 1'b1;
        expect_from(12'h000);
        step(1);
        reset = 1'b0;
        check("midrst_inst_valid", 32'(inst_valid), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        inst_ready = 1'b1;
        p0         = pops;
        step(8);
        check("midrst_pops", 32'(pops - p0), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
